// File: rtl/n_bit_adder.sv
// n_bit_adder: registered N-bit two's-complement adder with carry-in/carry-out.
//
// Operands are captured on a rising clk edge when in_valid is high, and the
// result {co, S} appears one cycle later with out_valid set. When in_valid is
// low, the result registers hold their last value and out_valid drops.
//
// Optional feature, macro N_BIT_ADDER_OVF_EN: adds a registered signed-overflow
// flag (ovf). This flag follows the same reset, capture and hold rules as S.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operands valid this cycle
//   A, B      N-bit operands (signed two's complement)
//   ci        carry-in, added as unsigned 0/1
//   S         registered sum, low N bits of A+B+ci
//   co        registered unsigned carry-out of bit N-1
//   out_valid S/co/ovf hold a fresh result this cycle
//   ovf       registered signed overflow (only with N_BIT_ADDER_OVF_EN)

module n_bit_adder #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic [N-1:0] S,
    output logic         co,
`ifdef N_BIT_ADDER_OVF_EN
    output logic         ovf,
`endif
    output logic         out_valid
);

    logic [N:0]   full_sum;
    logic [N-1:0] sum_d, sum_q;
    logic         co_d, co_q;
    logic         valid_d, valid_q;
`ifdef N_BIT_ADDER_OVF_EN
    logic         ovf_d, ovf_q;
`endif

    always_comb begin
        // Zero-extend to N+1 bits so the top bit is the unsigned carry.
        full_sum = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, ci};
        valid_d  = in_valid;
        // The hold path is selected whenever in_valid is low. This prevents
        // undriven operand bits from reaching the result registers.
        sum_d    = sum_q;
        co_d     = co_q;
`ifdef N_BIT_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (in_valid) begin
            sum_d = full_sum[N-1:0];
            co_d  = full_sum[N];
`ifdef N_BIT_ADDER_OVF_EN
            // Signed overflow: operands have the same sign, and the sum sign differs.
            ovf_d = (A[N-1] == B[N-1]) && (full_sum[N-1] != A[N-1]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
`ifdef N_BIT_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            co_q    <= co_d;
            valid_q <= valid_d;
`ifdef N_BIT_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign S         = sum_q;
    assign co        = co_q;
    assign out_valid = valid_q;
`ifdef N_BIT_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder (N=8), with directed and randomized stimulus.
module tb_n_bit_adder;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a, b;
    logic         ci;
    logic [N-1:0] s;
    logic         co;
    logic         out_valid;
`ifdef N_BIT_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    n_bit_adder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .ci        (ci),
        .S         (s),
        .co        (co),
`ifdef N_BIT_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Observed output bundle {out_valid, co, ovf, S}. ovf reads as 0 when the feature is absent.
    function automatic logic [N+2:0] obs();
`ifdef N_BIT_ADDER_OVF_EN
        return {out_valid, co, ovf, s};
`else
        return {out_valid, co, 1'b0, s};
`endif
    endfunction

    // Expected bundle. The ovf term is dropped when the feature is absent.
    function automatic logic [N+2:0] expv(input logic v, input logic c, input logic o,
                                          input logic [N-1:0] sv);
`ifdef N_BIT_ADDER_OVF_EN
        return {v, c, o, sv};
`else
        return {v, c, 1'b0, sv};
`endif
    endfunction

    // Reference model built from plain integer arithmetic on the operand values.
    function automatic void ref_add(input longint unsigned av, input longint unsigned bv,
                                    input longint unsigned cv, output logic [N-1:0] rs,
                                    output logic rc, output logic ro);
        longint unsigned usum;
        longint          sa, sb, ssum;
        usum = av + bv + cv;
        rs   = N'(usum % (64'd1 << N));
        rc   = (usum / (64'd1 << N)) != 0;
        sa   = (av >= (64'd1 << (N - 1))) ? longint'(av) - longint'(64'd1 << N) : longint'(av);
        sb   = (bv >= (64'd1 << (N - 1))) ? longint'(bv) - longint'(64'd1 << N) : longint'(bv);
        ssum = sa + sb + longint'(cv);
        ro   = (ssum > longint'((64'd1 << (N - 1)) - 1)) || (ssum < -longint'(64'd1 << (N - 1)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        ci       = cv;
    endtask

    task automatic test_reset();
        logic [N+2:0] e;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #2;
        checks++;
        if (obs() !== expv(0, 0, 0, '0)) begin
            failures++;
            $display("FAIL reset_initial: got %h want %h", obs(), expv(0, 0, 0, '0));
        end
        tick();
        #3 rst_n = 1'b1;
        drive(1'b1, 8'd5, 8'd10, 1'b0);
        tick();
        checks++;
        if (obs() !== expv(1, 0, 0, 8'd15)) begin
            failures++;
            $display("FAIL reset_precapture: got %h want %h", obs(), expv(1, 0, 0, 8'd15));
        end
        // Asserting reset between edges clears the outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        drive(1'b1, 8'd100, 8'd100, 1'b1);
        #1;
        checks++;
        if (obs() !== expv(0, 0, 0, '0)) begin
            failures++;
            $display("FAIL reset_async: got %h want %h", obs(), expv(0, 0, 0, '0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== expv(0, 0, 0, '0)) begin
                failures++;
                $display("FAIL reset_held%0d: got %h want %h", i, obs(), expv(0, 0, 0, '0));
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        e = expv(0, 0, 0, '0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_release_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] ta [7] = '{8'd5, 8'd30, 8'd5, 8'd127, 8'hFF, 8'd0, 8'd200};
        logic [N-1:0] tb [7] = '{8'd10, 8'hF6, 8'hF6, 8'hFF, 8'hFF, 8'd0, 8'd55};
        logic         tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [N-1:0] ws [7] = '{8'd15, 8'd20, 8'hFC, 8'd126, 8'hFF, 8'd0, 8'd0};
        logic         wc [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         wo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            tick();
            checks++;
            if (obs() !== expv(1, wc[i], wo[i], ws[i])) begin
                failures++;
                $display("FAIL basic%0d: got %h want %h", i, obs(), expv(1, wc[i], wo[i], ws[i]));
            end
        end
    endtask

`ifdef N_BIT_ADDER_OVF_EN
    task automatic test_ovf();
        logic [N-1:0] ta [4] = '{8'd127, 8'h80, 8'hFF, 8'h80};
        logic [N-1:0] tb [4] = '{8'd1, 8'hFF, 8'd1, 8'hFF};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [N-1:0] ws [4] = '{8'h80, 8'd127, 8'd0, 8'h80};
        logic         wc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic         wo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            tick();
            checks++;
            if (obs() !== expv(1, wc[i], wo[i], ws[i])) begin
                failures++;
                $display("FAIL ovf%0d: got %h want %h", i, obs(), expv(1, wc[i], wo[i], ws[i]));
            end
        end
    endtask
`endif

    task automatic test_hold();
        drive(1'b1, 8'd5, 8'd10, 1'b0);
        tick();
        checks++;
        if (obs() !== expv(1, 0, 0, 8'd15)) begin
            failures++;
            $display("FAIL hold_capture: got %h want %h", obs(), expv(1, 0, 0, 8'd15));
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(1'b0, 'x, 'x, 1'bx);
            else drive(1'b0, 8'hF0 ^ 8'(i * 37), 8'h0F ^ 8'(i * 91), 1'(i));
            tick();
            checks++;
            if (obs() !== expv(0, 0, 0, 8'd15)) begin
                failures++;
                $display("FAIL hold%0d: got %h want %h", i, obs(), expv(0, 0, 0, 8'd15));
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m_s;
        logic         m_co, m_ovf, v;
        logic [N-1:0] ra, rb;
        logic         rc;
        int           bad = 0;
        for (int i = 0; i < 1000; i++) begin
            v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            if (!v && $urandom_range(0, 3) == 0) drive(v, 'x, 'x, 1'bx);
            else drive(v, ra, rb, rc);
            if (v) ref_add(longint'(ra), longint'(rb), longint'(rc), m_s, m_co, m_ovf);
            tick();
            checks++;
            if (obs() !== expv(v, m_co, m_ovf, m_s)) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random%0d: got %h want %h", i, obs(), expv(v, m_co, m_ovf, m_s));
                bad++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rs;
        logic         rco, rov;
        drive(1'b1, 8'd127, 8'd127, 1'b0);
        tick();
        checks++;
        if (obs() !== expv(1, 0, 1, 8'd254)) begin
            failures++;
            $display("FAIL midrst_capture: got %h want %h", obs(), expv(1, 0, 1, 8'd254));
        end
        drive(1'b1, 8'd1, 8'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== expv(0, 0, 0, '0)) begin
            failures++;
            $display("FAIL midrst_clear: got %h want %h", obs(), expv(0, 0, 0, '0));
        end
        tick();
        drive(1'b1, 8'd200, 8'd100, 1'b1);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== expv(0, 0, 0, '0)) begin
            failures++;
            $display("FAIL midrst_release: got %h want %h", obs(), expv(0, 0, 0, '0));
        end
        ref_add(64'd200, 64'd100, 64'd1, rs, rco, rov);
        tick();
        checks++;
        if (obs() !== expv(1, rco, rov, rs)) begin
            failures++;
            $display("FAIL midrst_first: got %h want %h", obs(), expv(1, rco, rov, rs));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef N_BIT_ADDER_OVF_EN
        test_ovf();
`endif
        test_hold();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
